// File: rtl/spi_link_pkg.sv
// spi_link_pkg
//   Shared types and constants for the spi_link_sm host-side initiator.
//   op_e          : request opcodes carried on cmd_op
//   state_e       : framing FSM states of spi_link_master
//   CMD_REG/FIFO  : first byte of a register / fifo frame
//   *_FRAME_LEN   : bytes per frame, used to find the last byte index
//   frame_byte()  : byte to transmit at a given index of a frame

package spi_link_pkg;

   typedef enum logic [1:0] {
      OP_WR   = 2'b00,
      OP_RD   = 2'b01,
      OP_FIFO = 2'b10,
      OP_NOP  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_GAP,
      ST_HOLD,
      ST_CSHI
   } state_e;

   localparam logic [7:0] CMD_REG  = 8'h89;
   localparam logic [7:0] CMD_FIFO = 8'h8A;

   localparam int REG_FRAME_LEN  = 4;
   localparam int FIFO_FRAME_LEN = 3;

   function automatic logic [1:0] last_idx(input op_e op);
      return (op == OP_FIFO) ? 2'(FIFO_FRAME_LEN - 1) : 2'(REG_FRAME_LEN - 1);
   endfunction

   // Frames: write 89,{1,addr},wdata,00 | read 89,{0,addr},00,00 | fifo 8A,00,00
   function automatic logic [7:0] frame_byte(input op_e op, input logic [1:0] idx,
                                             input logic [6:0] addr, input logic [7:0] wdata);
      logic [7:0] b;
      b = 8'h00;
      case (op)
         OP_WR: begin
            case (idx)
               2'd0:    b = CMD_REG;
               2'd1:    b = {1'b1, addr};
               2'd2:    b = wdata;
               default: b = 8'h00;
            endcase
         end
         OP_RD: begin
            case (idx)
               2'd0:    b = CMD_REG;
               2'd1:    b = {1'b0, addr};
               default: b = 8'h00;
            endcase
         end
         OP_FIFO: begin
            if (idx == 2'd0) b = CMD_FIFO;
         end
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_link_master_shifter.sv
// spi_byte_shifter
//   One SPI mode-0 byte transfer, MSB first. A start pulse launches eight
//   SCLK periods (high CLK_DIV clk cycles, then low CLK_DIV cycles). MOSI
//   advances on each falling edge; MISO is shifted in at the end of each
//   high half. done is high for the final cycle of the last low half; a
//   start in that same cycle chains straight into the next byte.
// Ports
//   clk, rst  : system clock, async active-high reset
//   start     : launch a transfer (accepted when idle or on done)
//   tx_byte   : byte to send; its bit 7 is presented on mosi while idle
//   miso      : already-synchronised MISO
//   sclk,mosi : SPI lines
//   rx_byte   : received byte, valid from done onwards
//   done      : last cycle of the transfer

module spi_byte_shifter
   import spi_link_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic [7:0] rx_byte,
   output logic       done
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

   logic          active;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    tx_sr;
   logic [7:0]    rx_sr;
   logic          div_tc;

   assign div_tc  = (div_cnt == '0);
   assign done    = active && !sclk && div_tc && (bit_cnt == 3'd7);
   assign mosi    = active ? tx_sr[7] : tx_byte[7];
   assign rx_byte = rx_sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active  <= 1'b0;
         sclk    <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
      end else if (start && (!active || done)) begin
         active  <= 1'b1;
         sclk    <= 1'b1;
         div_cnt <= DIV_LOAD;
         bit_cnt <= '0;
         tx_sr   <= tx_byte;
      end else if (active) begin
         if (!div_tc) begin
            div_cnt <= div_cnt - DW'(1);
         end else if (sclk) begin
            // End of the high half: the 2-flop synchroniser delay puts the
            // MISO level seen near the rising edge on miso here.
            sclk    <= 1'b0;
            rx_sr   <= {rx_sr[6:0], miso};
            tx_sr   <= {tx_sr[6:0], 1'b0};
            div_cnt <= DIV_LOAD;
         end else if (bit_cnt == 3'd7) begin
            active  <= 1'b0;
         end else begin
            bit_cnt <= bit_cnt + 3'd1;
            sclk    <= 1'b1;
            div_cnt <= DIV_LOAD;
         end
      end
   end

endmodule

// File: rtl/spi_link_master.sv
// spi_link_master
//   SPI mode-0 initiator for the spi_link_sm register/FIFO link. Turns one
//   accepted request into a framed byte stream (CS_n low for the whole frame)
//   and returns the MISO byte of interest on rsp_data with a rsp_valid pulse.
//   Optional macro SPI_LINK_BURST_EN: a fifo op issues cmd_len+1 frames.
// Ports
//   clk, rst                 : system clock, async active-high reset
//   cmd_valid/cmd_ready      : request handshake (ready only when idle)
//   cmd_op/addr/wdata/len    : request fields, captured at acceptance
//   rsp_valid/rsp_data       : one-cycle completion pulse and response byte
//   busy                     : request in progress
//   spi_sclk/cs_n/mosi/miso  : SPI lines
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | CS_n high, cmd_ready high
// ST_SETUP | CS_n low, bit 7 of byte 0 on MOSI, CLK_DIV cycles
// ST_SHIFT | byte shifter running
// ST_GAP   | between bytes, SCLK low, GAP_CYCLES cycles
// ST_HOLD  | after last byte, CLK_DIV cycles before CS_n rises
// ST_CSHI  | CS_n high for CLK_DIV cycles (rsp_valid in first)

module spi_link_master
   import spi_link_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   input  logic [9:0] cmd_len,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       spi_sclk,
   output logic       spi_cs_n,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] T_DIV = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] T_GAP = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_e        state, state_nxt;
   op_e           op_q;
   logic [6:0]    addr_q;
   logic [7:0]    wdata_q;
   logic [1:0]    byte_idx;
   logic [TW-1:0] timer;
   logic          tmr_tc;
   logic          last_byte;
   logic          accept;
   logic          more_frames;
   logic          miso_s1, miso_s2;
   logic          sh_start, sh_done, sh_mosi;
   logic [7:0]    sh_tx, sh_rx;

`ifdef SPI_LINK_BURST_EN
   logic [9:0]    remain;
   assign more_frames = (remain != 10'd0);
`else
   logic          unused_len;
   assign unused_len  = ^cmd_len;
   assign more_frames = 1'b0;
`endif

   assign accept    = (state == ST_IDLE) && cmd_valid;
   assign tmr_tc    = (timer == '0);
   assign last_byte = (byte_idx == last_idx(op_q));
   assign sh_tx     = frame_byte(op_q, byte_idx, addr_q, wdata_q);

   spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .start   (sh_start),
      .tx_byte (sh_tx),
      .miso    (miso_s2),
      .sclk    (spi_sclk),
      .mosi    (sh_mosi),
      .rx_byte (sh_rx),
      .done    (sh_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (cmd_valid && (op_e'(cmd_op) != OP_NOP)) state_nxt = ST_SETUP;
         ST_SETUP: if (tmr_tc) state_nxt = ST_SHIFT;
         ST_SHIFT: begin
            if (sh_done) begin
               if (last_byte)            state_nxt = ST_HOLD;
               else if (GAP_CYCLES != 0) state_nxt = ST_GAP;
            end
         end
         ST_GAP:   if (tmr_tc) state_nxt = ST_SHIFT;
         ST_HOLD:  if (tmr_tc) state_nxt = ST_CSHI;
         ST_CSHI:  if (tmr_tc) state_nxt = more_frames ? ST_SETUP : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == ST_IDLE);
      busy      = (state != ST_IDLE);
      spi_cs_n  = !((state == ST_SETUP) || (state == ST_SHIFT) ||
                    (state == ST_GAP)   || (state == ST_HOLD));
      spi_mosi  = ((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_GAP)) ?
                  sh_mosi : 1'b0;
      // With no gap the next byte is chained in the done cycle of the previous one.
      sh_start  = ((state == ST_SETUP) && tmr_tc) ||
                  ((state == ST_GAP)   && tmr_tc) ||
                  ((state == ST_SHIFT) && sh_done && !last_byte && (GAP_CYCLES == 0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miso_s1 <= 1'b0;
         miso_s2 <= 1'b0;
      end else begin
         miso_s1 <= spi_miso;
         miso_s2 <= miso_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= OP_NOP;
         addr_q    <= '0;
         wdata_q   <= '0;
         byte_idx  <= '0;
         timer     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
`ifdef SPI_LINK_BURST_EN
         remain    <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         if (!tmr_tc) timer <= timer - TW'(1);
         if (accept) begin
            op_q     <= op_e'(cmd_op);
            addr_q   <= cmd_addr;
            wdata_q  <= cmd_wdata;
            byte_idx <= '0;
            timer    <= T_DIV;
`ifdef SPI_LINK_BURST_EN
            remain   <= (op_e'(cmd_op) == OP_FIFO) ? cmd_len : 10'd0;
`endif
            if (op_e'(cmd_op) == OP_NOP) begin
               rsp_valid <= 1'b1;
               rsp_data  <= 8'h00;
            end
         end else begin
            case (state)
               ST_SHIFT: begin
                  if (sh_done) begin
                     if (last_byte) begin
                        timer <= T_DIV;
                     end else begin
                        byte_idx <= byte_idx + 2'd1;
                        timer    <= T_GAP;
                     end
                  end
               end
               ST_HOLD: begin
                  if (tmr_tc) begin
                     // The byte of interest is always the last one of the frame.
                     rsp_valid <= 1'b1;
                     rsp_data  <= (op_q == OP_WR) ? 8'h00 : sh_rx;
                     timer     <= T_DIV;
                  end
               end
               ST_CSHI: begin
                  if (tmr_tc && more_frames) begin
                     byte_idx <= '0;
                     timer    <= T_DIV;
`ifdef SPI_LINK_BURST_EN
                     remain   <= remain - 10'd1;
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_link_master.sv
module tb_spi_link_master;

   localparam int D = 2;
   localparam int G = 8;
   localparam logic [1:0] T_WR = 2'd0, T_RD = 2'd1, T_FIFO = 2'd2, T_NOP = 2'd3;

   logic       clk, rst;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic [9:0] cmd_len;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       busy, spi_sclk, spi_cs_n, spi_mosi, spi_miso;

   spi_link_master #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_len   (cmd_len),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .spi_sclk  (spi_sclk),
      .spi_cs_n  (spi_cs_n),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- SPI target model: MOSI capture, MISO pattern ----------
   logic [7:0]  miso_pat [5];
   logic [7:0]  sh;
   logic [31:0] fbytes;
   int          nb = 0, s_bit = 0, s_byte = 0, frames = 0;
   int          rsp_cnt = 0;
   logic [7:0]  last_rsp = 8'h00;

   always @(negedge spi_cs_n) begin
      s_bit = 0; s_byte = 0; nb = 0; fbytes = 0;
      spi_miso = miso_pat[0][7];
   end

   always @(posedge spi_cs_n) frames++;

   always @(posedge spi_sclk) begin
      if (spi_cs_n === 1'b0) begin
         sh = {sh[6:0], spi_mosi};
         s_bit++;
         if (s_bit == 8) begin
            fbytes = {fbytes[23:0], sh};
            nb++;
            s_bit = 0;
            if (s_byte < 4) s_byte++;
         end
      end
   end

   always @(negedge spi_sclk) begin
      if (spi_cs_n === 1'b0) begin
         logic [7:0] b;
         b = miso_pat[s_byte];
         spi_miso = b[7 - s_bit];
      end
   end

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         rsp_cnt++;
         last_rsp = rsp_data;
      end
   end

   // ---------------- reference model ---------------------------------------
   function automatic int ref_nbytes(input logic [1:0] op);
      case (op)
         T_WR, T_RD: return 4;
         T_FIFO:     return 3;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_frame(input logic [1:0] op, input logic [6:0] a,
                                             input logic [7:0] w);
      case (op)
         T_WR:    return {8'h89, 1'b1, a, w, 8'h00};
         T_RD:    return {8'h89, 1'b0, a, 16'h0000};
         T_FIFO:  return {8'h00, 8'h8A, 16'h0000};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [7:0] ref_rsp(input logic [1:0] op);
      if (op == T_RD)   return miso_pat[3];
      if (op == T_FIFO) return miso_pat[2];
      return 8'h00;
   endfunction

   function automatic int ref_lat(input logic [1:0] op);
      int n;
      n = ref_nbytes(op);
      if (n == 0) return 1;
      return 1 + D + n * 16 * D + (n - 1) * G + D;
   endfunction

   function automatic int ref_frames(input logic [1:0] op, input logic [9:0] len);
      if (op == T_NOP) return 0;
`ifdef SPI_LINK_BURST_EN
      if (op == T_FIFO) return int'(len) + 1;
`endif
      return 1;
   endfunction

   // ---------------- one request, checked end to end -----------------------
   task automatic do_op(input logic [1:0] op, input logic [6:0] a, input logic [7:0] w,
                        input logic [9:0] len, input logic [7:0] exp_rsp,
                        input logic [31:0] exp_bytes, input string tag);
      int acc, first, r0, f0, n, n_rsp;
      @(negedge clk);
      cmd_op = op; cmd_addr = a; cmd_wdata = w; cmd_len = len; cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
      acc = cyc; r0 = rsp_cnt; f0 = frames; first = -1;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (i == 0) begin
            cmd_valid = 1'b0;
            cmd_op = 2'($urandom); cmd_addr = 7'($urandom);
            cmd_wdata = 8'($urandom); cmd_len = 10'($urandom);
         end
         if (rsp_valid === 1'b1 && first < 0) first = cyc;
         if (first >= 0 && busy === 1'b0) break;
      end
      repeat (D + 3) @(negedge clk);
      n_rsp = (op == T_NOP) ? 1 : ref_frames(op, len);
      chk({tag, "_lat"},    32'(first - acc),   32'(ref_lat(op)));
      chk({tag, "_nrsp"},   32'(rsp_cnt - r0),  32'(n_rsp));
      chk({tag, "_frames"}, 32'(frames - f0),   32'(ref_frames(op, len)));
      chk({tag, "_rsp"},    {24'b0, last_rsp},  {24'b0, exp_rsp});
      chk({tag, "_busy"},   {31'b0, busy},      32'd0);
      if (op != T_NOP) begin
         chk({tag, "_nbytes"}, 32'(nb), 32'(ref_nbytes(op)));
         chk({tag, "_mosi"},   fbytes,  exp_bytes);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [6:0]  addr;
      logic [7:0]  wdata;
      logic [39:0] pat;
      logic [7:0]  exp_rsp;
      logic [31:0] exp_bytes;
   } vec_t;

   vec_t vecs [6];

   task automatic load_pat(input logic [39:0] p);
      for (int k = 0; k < 5; k++) miso_pat[k] = p[39 - 8 * k -: 8];
   endtask

   initial begin
      int acc1, acc2, rsp_c, r0, f0, n;
      logic [1:0] op;
      logic [6:0] a;
      logic [7:0] w;
      logic [9:0] len;

      vecs[0] = '{T_WR,   7'h24, 8'h02, 40'h5A5A5A5A5A, 8'h00, 32'h89A40200};
      vecs[1] = '{T_RD,   7'h24, 8'h00, 40'h5A5A5A025A, 8'h02, 32'h89240000};
      vecs[2] = '{T_FIFO, 7'h00, 8'h00, 40'h5A5AC35A5A, 8'hC3, 32'h008A0000};
      vecs[3] = '{T_NOP,  7'h11, 8'h22, 40'h5A5A5A5A5A, 8'h00, 32'h00000000};
      vecs[4] = '{T_RD,   7'h7F, 8'h00, 40'h112233A544, 8'hA5, 32'h897F0000};
      vecs[5] = '{T_WR,   7'h7F, 8'hFF, 40'hFFFFFFFFFF, 8'h00, 32'h89FFFF00};

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0;
      cmd_len = '0; spi_miso = 1'b0;
      load_pat(40'h0);

      // Reset values; a request held during reset must not be taken.
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_busy",  {31'b0, busy},      32'd0);
      chk("rst_rspv",  {31'b0, rsp_valid}, 32'd0);
      chk("rst_rspd",  {24'b0, rsp_data},  32'd0);
      chk("rst_sclk",  {31'b0, spi_sclk},  32'd0);
      chk("rst_csn",   {31'b0, spi_cs_n},  32'd1);
      chk("rst_mosi",  {31'b0, spi_mosi},  32'd0);
      cmd_op = T_WR; cmd_valid = 1'b1;
      repeat (2) @(negedge clk);
      cmd_valid = 1'b0;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_win_busy", {31'b0, busy},     32'd0);
      chk("rst_win_csn",  {31'b0, spi_cs_n}, 32'd1);

      // Directed table.
      for (int i = 0; i < 6; i++) begin
         load_pat(vecs[i].pat);
         do_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, 10'd0, vecs[i].exp_rsp,
               vecs[i].exp_bytes, $sformatf("vec%0d", i));
      end

      // cmd_valid held across a fifo frame: next acceptance only once back in idle.
      load_pat(40'h5A5AC35A5A);
      @(negedge clk);
      cmd_op = T_FIFO; cmd_addr = '0; cmd_wdata = '0; cmd_len = '0; cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      acc1 = cyc; acc2 = -1; rsp_c = -1; f0 = frames;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (i == 0) chk("hold_busy", {31'b0, busy}, 32'd1);
         if (rsp_valid === 1'b1) rsp_c = cyc;
         if (cmd_ready === 1'b1) begin acc2 = cyc; break; end
      end
      chk("hold_acc2",    32'(acc2 - acc1),  32'(ref_lat(T_FIFO) + D));
      chk("hold_acc_gap", 32'(acc2 - rsp_c), 32'(D));
      chk("hold_rsp1",    {24'b0, last_rsp}, 32'h0000_00C3);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while ((busy !== 1'b0) && n < 2000) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      chk("hold_frames", 32'(frames - f0), 32'd2);
      chk("hold_rsp2",   {24'b0, last_rsp}, 32'h0000_00C3);

      // Reset in the middle of a write's shift phase.
      load_pat(40'h5A5A5A5A5A);
      @(negedge clk);
      cmd_op = T_WR; cmd_addr = 7'h24; cmd_wdata = 8'h02; cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid_csn_low", {31'b0, spi_cs_n}, 32'd0);
      r0 = rsp_cnt;
      rst = 1'b1;
      #1;
      chk("mid_csn",   {31'b0, spi_cs_n},  32'd1);
      chk("mid_sclk",  {31'b0, spi_sclk},  32'd0);
      chk("mid_mosi",  {31'b0, spi_mosi},  32'd0);
      chk("mid_busy",  {31'b0, busy},      32'd0);
      chk("mid_ready", {31'b0, cmd_ready}, 32'd1);
      chk("mid_rspd",  {24'b0, rsp_data},  32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_norsp", 32'(rsp_cnt - r0), 32'd0);
      do_op(T_WR, 7'h24, 8'h02, 10'd0, 8'h00, 32'h89A40200, "after_rst");

      // Randomised requests against the model.
      for (int i = 0; i < 10; i++) begin
         op = 2'($urandom_range(0, 3));
         a = 7'($urandom); w = 8'($urandom); len = 10'($urandom_range(0, 3));
         for (int k = 0; k < 5; k++) miso_pat[k] = 8'($urandom);
         do_op(op, a, w, len, ref_rsp(op), ref_frame(op, a, w), $sformatf("rnd%0d", i));
      end

      // fifo with cmd_len=3: one frame normally, four with bursts built in.
      load_pat(40'h0102E70304);
      do_op(T_FIFO, 7'h00, 8'h00, 10'd3, 8'hE7, 32'h008A0000, "burst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
